// File: rtl/mem_arbiter_if.sv
// Request/grant and memory-bus signals shared between mem_arbiter, its two
// requesters and the RAM.
interface mem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
);
    logic          req0, req1;
    logic          lock0, lock1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port synchronous RAM, with
// locked bursts capped at MAX_BURST accesses per grant.
module mem_arbiter #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

    state_e        state_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;
    logic          rvalid0_q, rvalid1_q;

    logic          acc0, acc1;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    // Grants come from state alone so there is no comb path from req to gnt.
    assign bus.gnt0    = (state_q == StBusy0);
    assign bus.gnt1    = (state_q == StBusy1);
    assign acc0        = bus.gnt0 & bus.req0;
    assign acc1        = bus.gnt1 & bus.req1;
    assign cnt_inc     = cnt_q + CW'(1);
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata   = bus.mem_rdata;

    always_comb begin
        addr_sel      = '0;
        wdata_sel     = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        if (acc0) begin
            bus.mem_en = 1'b1;
            bus.mem_we = bus.we0;
            addr_sel   = bus.addr0;
            wdata_sel  = bus.wdata0;
        end else if (acc1) begin
            bus.mem_en = 1'b1;
            bus.mem_we = bus.we1;
            addr_sel   = bus.addr1;
            wdata_sel  = bus.wdata1;
        end
        bus.mem_addr  = addr_sel;
        bus.mem_wdata = wdata_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= acc0 & ~bus.we0;
            rvalid1_q <= acc1 & ~bus.we1;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    // On a tie the port that did not own the memory last wins.
                    if (bus.req0 && (!bus.req1 || last_q)) state_q <= StBusy0;
                    else if (bus.req1)                      state_q <= StBusy1;
                end
                StBusy0: begin
                    if (acc0 && bus.lock0 && (cnt_inc < CW'(MAX_BURST))) begin
                        cnt_q <= cnt_inc;
                    end else begin
                        last_q <= 1'b0;
                        cnt_q  <= '0;
                        if (bus.req1)      state_q <= StBusy1;
                        else if (!bus.req0) state_q <= StIdle;
                    end
                end
                StBusy1: begin
                    if (acc1 && bus.lock1 && (cnt_inc < CW'(MAX_BURST))) begin
                        cnt_q <= cnt_inc;
                    end else begin
                        last_q <= 1'b1;
                        cnt_q  <= '0;
                        if (bus.req0)      state_q <= StBusy0;
                        else if (!bus.req1) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: one row per clock cycle, with a
// behavioural RAM answering the memory bus.
module tb_mem_arbiter;
    localparam logic [31:0] W0   = 32'h0000_5A5A;
    localparam logic [31:0] RD10 = 32'hDEAD_BEEF;
    localparam logic [31:0] RD11 = 32'hC0DE_0011;
    localparam logic [31:0] WR20 = 32'h1234_5678;

    typedef struct {
        logic        rst, req0, req1, lock0, lock1, we0, we1;
        logic [7:0]  addr0, addr1;
        logic [31:0] wdata1;
        logic [1:0]  e_gnt, e_rv;
        logic        e_en, e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   row = 0;

    logic [31:0] mem [256];
    logic [31:0] rd_q = '0;
    vec_t        vq[$];

    mem_arbiter_if #(.AW(8), .DW(32)) bus ();

    mem_arbiter #(.AW(8), .DW(32), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    function automatic vec_t mk(
        input logic r, q0, q1, l0, l1, w0, w1,
        input logic [7:0] a0, a1, input logic [31:0] wd1,
        input logic [1:0] eg, erv, input logic een, ewe,
        input logic [7:0] ea, input logic [31:0] ewd, erd);
        vec_t v;
        v.rst = r; v.req0 = q0; v.req1 = q1; v.lock0 = l0; v.lock1 = l1;
        v.we0 = w0; v.we1 = w1; v.addr0 = a0; v.addr1 = a1; v.wdata1 = wd1;
        v.e_gnt = eg; v.e_rv = erv; v.e_en = een; v.e_we = ewe;
        v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst        = v.rst;
        bus.req0   = v.req0;
        bus.req1   = v.req1;
        bus.lock0  = v.lock0;
        bus.lock1  = v.lock1;
        bus.we0    = v.we0;
        bus.we1    = v.we1;
        bus.addr0  = v.addr0;
        bus.addr1  = v.addr1;
        bus.wdata0 = W0;
        bus.wdata1 = v.wdata1;
        @(negedge clk);
        chk("gnt",       {bus.gnt1, bus.gnt0},       v.e_gnt);
        chk("rvalid",    {bus.rvalid1, bus.rvalid0}, v.e_rv);
        chk("mem_en",    bus.mem_en,                 v.e_en);
        chk("mem_we",    bus.mem_we,                 v.e_we);
        chk("mem_addr",  bus.mem_addr,               v.e_addr);
        chk("mem_wdata", bus.mem_wdata,              v.e_wdata);
        if (v.e_rv != 2'b00) chk("rdata", bus.rdata, v.e_rdata);
        @(posedge clk);
        #1;
        row++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[8'h10] = RD10;

        // Reset state
        vq.push_back(mk(1,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b00,2'b00,0,0,8'h00,0,0));
        // Tie after reset: port 0, then port 1, then port 0 again, no bubble
        vq.push_back(mk(0,1,1,0,0,0,0, 8'h10,8'h11,0,     2'b00,2'b00,0,0,8'h00,0,0));
        vq.push_back(mk(0,1,1,0,0,0,0, 8'h10,8'h11,0,     2'b01,2'b00,1,0,8'h10,W0,0));
        vq.push_back(mk(0,1,1,0,0,0,0, 8'h10,8'h11,0,     2'b10,2'b01,1,0,8'h11,0,RD10));
        vq.push_back(mk(0,1,1,0,0,0,0, 8'h10,8'h11,0,     2'b01,2'b10,1,0,8'h10,W0,RD11));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b10,2'b01,0,0,8'h00,0,RD10));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b00,2'b00,0,0,8'h00,0,0));
        // Single read on port 0
        vq.push_back(mk(0,1,0,0,0,0,0, 8'h10,8'h00,0,     2'b00,2'b00,0,0,8'h00,0,0));
        vq.push_back(mk(0,1,0,0,0,0,0, 8'h10,8'h00,0,     2'b01,2'b00,1,0,8'h10,W0,0));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b01,2'b01,0,0,8'h00,0,RD10));
        // Port 1 write then read back
        vq.push_back(mk(0,0,1,0,0,0,1, 8'h00,8'h20,WR20,  2'b00,2'b00,0,0,8'h00,0,0));
        vq.push_back(mk(0,0,1,0,0,0,1, 8'h00,8'h20,WR20,  2'b10,2'b00,1,1,8'h20,WR20,0));
        vq.push_back(mk(0,0,1,0,0,0,0, 8'h00,8'h20,0,     2'b10,2'b00,1,0,8'h20,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b10,2'b10,0,0,8'h00,0,WR20));
        // Locked port-0 burst under contention: four accesses, then port 1
        vq.push_back(mk(0,1,1,1,0,0,0, 8'h10,8'h11,0,     2'b00,2'b00,0,0,8'h00,0,0));
        vq.push_back(mk(0,1,1,1,0,0,0, 8'h10,8'h11,0,     2'b01,2'b00,1,0,8'h10,W0,0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0,1,1,1,0,0,0, 8'h10,8'h11,0, 2'b01,2'b01,1,0,8'h10,W0,RD10));
        vq.push_back(mk(0,1,1,1,0,0,0, 8'h10,8'h11,0,     2'b10,2'b01,1,0,8'h11,0,RD10));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b01,2'b10,0,0,8'h00,0,RD11));
        // Burst cap with no contention: grant held, counter wraps every 4
        vq.push_back(mk(0,1,0,1,0,0,0, 8'h10,8'h00,0,     2'b00,2'b00,0,0,8'h00,0,0));
        vq.push_back(mk(0,1,0,1,0,0,0, 8'h10,8'h00,0,     2'b01,2'b00,1,0,8'h10,W0,0));
        for (int i = 0; i < 9; i++)
            vq.push_back(mk(0,1,0,1,0,0,0, 8'h10,8'h00,0, 2'b01,2'b01,1,0,8'h10,W0,RD10));
        // Port 1 arrives on the 11th access (cnt=2): one more, then handover
        vq.push_back(mk(0,1,1,1,0,0,0, 8'h10,8'h11,0,     2'b01,2'b01,1,0,8'h10,W0,RD10));
        vq.push_back(mk(0,1,1,1,0,0,0, 8'h10,8'h11,0,     2'b01,2'b01,1,0,8'h10,W0,RD10));
        vq.push_back(mk(0,0,1,0,0,0,0, 8'h00,8'h11,0,     2'b10,2'b01,1,0,8'h11,0,RD10));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b10,2'b10,0,0,8'h00,0,RD11));
        vq.push_back(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0,     2'b00,2'b00,0,0,8'h00,0,0));

        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
        bus.we0 = 0; bus.we1 = 0; bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        @(posedge clk);
        #1;

        foreach (vq[i]) apply(vq[i]);

        // Reset mid-burst: single access leaves last=0, then locked burst is
        // reset on its 2nd access; afterwards a tie must go to port 0 again.
        apply(mk(0,1,0,0,0,0,0, 8'h10,8'h00,0, 2'b00,2'b00,0,0,8'h00,0,0));
        apply(mk(0,1,0,0,0,0,0, 8'h10,8'h00,0, 2'b01,2'b00,1,0,8'h10,W0,0));
        apply(mk(0,1,0,1,0,0,0, 8'h10,8'h00,0, 2'b01,2'b01,1,0,8'h10,W0,RD10));
        apply(mk(1,1,0,1,0,0,0, 8'h10,8'h00,0, 2'b01,2'b01,1,0,8'h10,W0,RD10));
        apply(mk(0,1,1,0,0,0,0, 8'h10,8'h11,0, 2'b00,2'b00,0,0,8'h00,0,0));
        apply(mk(0,1,1,0,0,0,0, 8'h10,8'h11,0, 2'b01,2'b00,1,0,8'h10,W0,0));
        apply(mk(0,0,0,0,0,0,0, 8'h00,8'h00,0, 2'b10,2'b01,0,0,8'h00,0,RD10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port synchronous RAM between two requesters.
- Port 0 is the linked-list sum engine: its controller issues node/value fetches.
- Port 1 is the host/loader that writes list nodes and reads results.
- Round-robin grant with optional locked bursts, so the sum engine can fetch value and next-pointer back-to-back; MAX_BURST caps the burst to prevent starvation.

Parameters:
- AW, 8, address width.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive accesses per grant (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req0, req1  input  1  access request; held until the access cycle completes.
- lock0, lock1  input  1  request to keep ownership after the current access.
- we0, we1  input  1  1 = write, 0 = read.
- addr0, addr1  input  AW  access address.
- wdata0, wdata1  input  DW  write data.
- gnt0, gnt1  output  1  requester owns memory; an access occurs in every cycle where gnt_i & req_i.
- rvalid0, rvalid1  output  1  read data valid for requester i.
- rdata  output  DW  read data, mem_rdata passed through.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid 1 cycle after a read with mem_en=1.

Behaviour:
- States: IDLE, BUSY0, BUSY1.
- Registers:
  - last: last owner, 1 bit.
  - cnt: burst counter, clog2(MAX_BURST)+1 bits.
  - rvalid0, rvalid1.
- Reset: state=IDLE, last=1 (port 0 wins the first tie), cnt=0, rvalid0=rvalid1=0. All mem_* outputs are 0 while IDLE.
- Reset mid-burst: forces IDLE next cycle and drops any pending rvalid. The in-flight access is abandoned.
- gnt_i = (state==BUSY_i). Decoded from state only; no combinational path from req.
- Access cycle: gnt_i & req_i.
  - mem_en=1; mem_we=we_i; mem_addr=addr_i; mem_wdata=wdata_i.
  - Otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- rvalid_i is registered: rvalid_i(t+1) = access cycle for i at t and we_i=0. Writes produce no rvalid.
- Latency: req_i rises at cycle t while IDLE → gnt_i and access at t+1 → rvalid_i at t+2.
- IDLE transitions:
  - Only req0 → BUSY0. Only req1 → BUSY1.
  - Both → BUSY of the port ≠ last.
  - cnt=0 on entry.
- BUSY_i, access cycle, continue: if lock_i=1 and cnt+1 < MAX_BURST, stay BUSY_i and cnt++.
- BUSY_i, release: on an access cycle with lock_i=0 or cnt+1==MAX_BURST, or in any cycle with req_i=0.
  - last=i and cnt=0.
  - If req of the other port = 1 → go directly to BUSY_other (no idle bubble).
  - Else if req_i=1 (burst cap hit, other idle) → stay BUSY_i with cnt=0.
  - Else → IDLE.
- MAX_BURST=1 degenerates to strict per-access alternation under contention.
- Both lock inputs are ignored outside the owner's access cycles.
- Requesters must not change addr/we/wdata while req is high and gnt is low.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x10, mem[0x10]=0xDEADBEEF at t0 → gnt0=1 and mem_en=1, mem_addr=0x10 at t0+1; rvalid0=1, rdata=0xDEADBEEF at t0+2; gnt0 drops after req0 is released.
- Tie after reset: req0=req1=1, lock=0 at t0 → port 0 accesses at t0+1, port 1 at t0+2 with no bubble, port 0 again at t0+3 (alternation).
- Locked burst: MAX_BURST=4, req0=lock0=1, req1=1 → four consecutive port-0 accesses, then gnt1 on the fifth cycle.
- Write then read: port 1 writes 0x12345678 to addr 0x20, then reads addr 0x20 → mem_we=1 on the write cycle with no rvalid1; rvalid1 with 0x12345678 one cycle after the read.
- Burst cap with no contention: MAX_BURST=4, req0=lock0=1, req1=0 for 10 cycles → gnt0 held continuously, access every cycle, cnt wraps every 4 accesses.
- Reset mid-burst: rst=1 during the 2nd access of a locked port-0 burst → next cycle IDLE, gnt0=gnt1=0, rvalid0=0, mem_en=0; with both requesting after rst deasserts, port 0 wins.
